dpe_feed_ctrl: RTL

//  Upstream driver for one dpe: accepts a weight stream and an activation-vector stream (valid/ready).

---
 rtl/dpe_feed_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dpe_feed_ctrl.sv
// dpe_feed_ctrl -- upstream feeder for one dpe (dot-product engine).
//   Serialises weight words into the dpe's two ping-pong weight banks and
//   streams activation vectors against the bank that is currently active.
//   Optional build macro: DPE_FEED_PERF_EN adds saturating stall counters.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   w_data/w_valid/w_ready  weight word stream (valid/ready)
//   v_data/v_valid/v_last/v_ready
//                           activation stream; v_last releases the active bank
//   dpe_din_b, dpe_ena, dpe_reg_ctrl
//                           weight word, strobe and target bank to the dpe
//   dpe_din_a, dpe_valid_a, dpe_load_sel
//                           vector, strobe and compute bank to the dpe
//   bank_full[1:0]          per-bank FULL flag (registered)
//   perf_w_stall, perf_v_stall (DPE_FEED_PERF_EN only)
//                           cycles with valid high and ready low, saturating
module dpe_feed_ctrl #(
  parameter int DATAW       = 8,
  parameter int LANES       = 40,
  parameter int DOTW        = 10,
  parameter int DOT_PER_DSP = 3,
  parameter int NUM_DSP     = LANES / DOTW,
  parameter int WLOAD_DEPTH = NUM_DSP * DOT_PER_DSP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATAW*DOTW-1:0]  w_data,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DATAW*LANES-1:0] v_data,
  input  logic                   v_valid,
  input  logic                   v_last,
  output logic                   v_ready,
  output logic [DATAW*DOTW-1:0]  dpe_din_b,
  output logic                   dpe_ena,
  output logic                   dpe_reg_ctrl,
  output logic [DATAW*LANES-1:0] dpe_din_a,
  output logic                   dpe_valid_a,
  output logic                   dpe_load_sel,
  output logic [1:0]             bank_full
`ifdef DPE_FEED_PERF_EN
  ,
  output logic [31:0]            perf_w_stall,
  output logic [31:0]            perf_v_stall
`endif
);

  localparam int CNTW = $clog2(WLOAD_DEPTH + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WLOAD_DEPTH - 1);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_LOADING = 2'd1, B_FULL = 2'd2} bank_t;
  typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} ld_t;

  ld_t            state, state_next;
  bank_t          bank_q [2];
  bank_t          bank_d [2];
  logic           active_q;
  logic           tgt_q;
  logic [CNTW-1:0] cnt_q;

  logic can_start, pick_bank, cur_bank;
  logic w_acc, v_acc, last_word;

  // Bank choice for a new load: an empty active bank is what compute waits
  // on, so it is filled first; otherwise the idle (non-active) bank if empty.
  always_comb begin
    can_start = (bank_q[active_q] == B_EMPTY) || (bank_q[~active_q] == B_EMPTY);
    pick_bank = (bank_q[active_q] == B_EMPTY) ? active_q : ~active_q;
    cur_bank  = (state == S_LOAD) ? tgt_q : pick_bank;
  end

  // Loader FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Loader FSM: next state (a single-word load returns straight to IDLE).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (w_acc && !last_word) state_next = S_LOAD;
               else                     state_next = S_IDLE;
      S_LOAD:  if (last_word)           state_next = S_IDLE;
               else                     state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  // Loader FSM: outputs and handshake decodes; readies are held low in reset.
  always_comb begin
    w_ready = 1'b0;
    case (state)
      S_IDLE:  w_ready = ~reset & can_start;
      S_LOAD:  w_ready = ~reset;
      default: w_ready = 1'b0;
    endcase
    v_ready   = ~reset & (bank_q[active_q] == B_FULL);
    w_acc     = w_valid & w_ready;
    v_acc     = v_valid & v_ready;
    last_word = w_acc & (cnt_q == CNT_LAST);
  end

  // Next bank states. The load target is never FULL and v_last only hits the
  // FULL active bank, so the two updates never touch the same bank.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (w_acc) begin
      bank_d[cur_bank] = last_word ? B_FULL : B_LOADING;
    end else begin
      bank_d[cur_bank] = bank_q[cur_bank];
    end
    if (v_acc && v_last) begin
      bank_d[active_q] = B_EMPTY;
    end else begin
      bank_d[active_q] = bank_d[active_q];
    end
  end

  // Bank bookkeeping, word counter and all dpe-facing registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]    <= B_EMPTY;
      bank_q[1]    <= B_EMPTY;
      active_q     <= 1'b0;
      tgt_q        <= 1'b0;
      cnt_q        <= '0;
      bank_full    <= 2'b00;
      dpe_din_b    <= '0;
      dpe_ena      <= 1'b0;
      dpe_reg_ctrl <= 1'b0;
      dpe_din_a    <= '0;
      dpe_valid_a  <= 1'b0;
      dpe_load_sel <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      bank_full <= {bank_d[1] == B_FULL, bank_d[0] == B_FULL};
      dpe_ena     <= w_acc;
      dpe_valid_a <= v_acc;
      // load_sel follows the pre-toggle bank so the last vector keeps its bank.
      dpe_load_sel <= active_q;
      if (v_acc && v_last) active_q <= ~active_q;
      if (w_acc) begin
        tgt_q        <= cur_bank;
        cnt_q        <= last_word ? '0 : cnt_q + 1'b1;
        dpe_din_b    <= w_data;
        dpe_reg_ctrl <= cur_bank;
      end
      if (v_acc) dpe_din_a <= v_data;
    end
  end

`ifdef DPE_FEED_PERF_EN
  // Saturating stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_w_stall <= 32'd0;
      perf_v_stall <= 32'd0;
    end else begin
      if (w_valid && !w_ready && perf_w_stall != 32'hFFFF_FFFF) perf_w_stall <= perf_w_stall + 32'd1;
      if (v_valid && !v_ready && perf_v_stall != 32'hFFFF_FFFF) perf_v_stall <= perf_v_stall + 32'd1;
    end
  end
`endif

endmodule
